// File: rtl/regs_access_ctrl.sv
// Arbitrates the GPR write port and debug read port between core writeback and JTAG debug access.
// Optional bulk-clear sequencer is built in when the REGS_CLR_EN macro is defined.
module regs_access_ctrl #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_we_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              hold_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic [ADDR_W-1:0] rf_raddr_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    input  logic              clr_req_i,
    output logic              clr_busy_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W:0] LIMIT_V = (CNT_W + 1)'(STARVE_LIMIT);

`ifdef REGS_CLR_EN
    typedef enum logic [1:0] {IDLE, PEND, RESP, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, PEND, RESP} state_t;
`endif

    state_t              state;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [CNT_W-1:0]    wait_cnt;
    logic [CNT_W:0]      wait_inc;
    logic                clr_go;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

`ifdef REGS_CLR_EN
    logic [ADDR_W-1:0]   clr_idx;

    assign clr_go = (state == IDLE) && clr_req_i;
`else
    logic unused_clr_req;

    assign unused_clr_req = clr_req_i;
    assign clr_go         = 1'b0;
    assign clr_busy_o     = 1'b0;
`endif

    // A clear request in IDLE takes the slot, so debug is refused that cycle.
    assign dbg_gnt_o  = (state == IDLE) && !clr_go;
    assign rf_raddr_o = (state == PEND) ? lat_addr : '0;
    assign wait_inc   = {1'b0, wait_cnt} + 1'b1;

    // NOTE: every signal gets a default first so no path through the block infers a latch.
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        if (ex_we_i) begin
            sel_we   = 1'b1;
            sel_addr = ex_waddr_i;
            sel_data = ex_wdata_i;
        end else if (state == PEND && lat_we) begin
            sel_we   = 1'b1;
            sel_addr = lat_addr;
            sel_data = lat_wdata;
`ifdef REGS_CLR_EN
        end else if (state == CLEAR) begin
            sel_we   = 1'b1;
            sel_addr = clr_idx;
`endif
        end
    end

    // x0 is hardwired zero: the write is swallowed but the access still completes.
    assign rf_we_o    = sel_we && (sel_addr != '0);
    assign rf_waddr_o = sel_addr;
    assign rf_wdata_o = sel_data;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            wait_cnt     <= '0;
            dbg_rvalid_o <= 1'b0;
            dbg_rdata_o  <= '0;
            hold_o       <= 1'b0;
`ifdef REGS_CLR_EN
            clr_idx      <= '0;
            clr_busy_o   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef REGS_CLR_EN
                    if (clr_go) begin
                        state      <= CLEAR;
                        clr_idx    <= ADDR_W'(1);
                        clr_busy_o <= 1'b1;
                        hold_o     <= 1'b1;
                    end else
`endif
                    if (dbg_req_i) begin
                        state     <= PEND;
                        lat_we    <= dbg_we_i;
                        lat_addr  <= dbg_addr_i;
                        lat_wdata <= dbg_wdata_i;
                        wait_cnt  <= '0;
                    end
                end
                PEND: begin
                    if (!ex_we_i) begin
                        if (!lat_we) begin
                            dbg_rdata_o <= (lat_addr == '0) ? '0 : rf_rdata_i;
                        end
                        dbg_rvalid_o <= 1'b1;
                        hold_o       <= 1'b0;
                        state        <= RESP;
                    end else begin
                        // Saturate so a long core burst cannot wrap the counter.
                        if (wait_inc <= LIMIT_V) begin
                            wait_cnt <= wait_inc[CNT_W-1:0];
                        end
                        if (wait_inc >= LIMIT_V) begin
                            hold_o <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    dbg_rvalid_o <= 1'b0;
                    state        <= IDLE;
                end
`ifdef REGS_CLR_EN
                CLEAR: begin
                    if (!ex_we_i) begin
                        if (clr_idx == '1) begin
                            state      <= IDLE;
                            clr_busy_o <= 1'b0;
                            hold_o     <= 1'b0;
                        end else begin
                            clr_idx <= clr_idx + 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
